// File: rtl/hazard_ctrl.sv
// Hazard control unit for a 5-stage pipeline: load-use / RAW stall FSM,
// branch flush, ALU operand forwarding select and saturating event counters.
// Build option: define HAZARD_FWD_EN to enable forwarding; the detector then
// stalls only on load-use. Without it, forwarding is tied off and every RAW
// dependency on a live writer stalls until that writer has retired.
module hazard_ctrl #(
    parameter int REG_DIR_WIDTH = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_DIR_WIDTH-1:0] id_rs,
    input  logic [REG_DIR_WIDTH-1:0] id_rt,
    input  logic                     idex_memread,
    input  logic                     idex_regwrite,
    input  logic [REG_DIR_WIDTH-1:0] idex_wreg,
    input  logic [REG_DIR_WIDTH-1:0] ex_rs,
    input  logic [REG_DIR_WIDTH-1:0] ex_rt,
    input  logic                     exmem_regwrite,
    input  logic                     exmem_branch,
    input  logic                     exmem_zero,
    input  logic [REG_DIR_WIDTH-1:0] exmem_wreg,
    input  logic                     memwb_regwrite,
    input  logic [REG_DIR_WIDTH-1:0] memwb_wreg,
    output logic                     pc_hold,
    output logic                     ifid_hold,
    output logic                     idex_bubble,
    output logic                     ifid_flush,
    output logic                     idex_flush,
    output logic                     exmem_flush,
    output logic [1:0]               fwd_a,
    output logic [1:0]               fwd_b,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             scnt_q, scnt_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

    logic                   br_taken;
    logic                   hazard;
    logic [1:0]             req_cycles;
    logic                   stall_req;
    logic [1:0]             fwd_a_raw, fwd_b_raw;
    logic                   unused_inputs;

    // Register 0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic reg_hit(input logic [REG_DIR_WIDTH-1:0] writer,
                                     input logic [REG_DIR_WIDTH-1:0] src);
        return (writer != '0) && (writer == src);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign br_taken = exmem_branch & exmem_zero;

`ifdef HAZARD_FWD_EN
    // Forwarding covers ALU results; only a load feeding the next instruction must wait one cycle.
    always_comb begin
        hazard     = idex_memread & (reg_hit(idex_wreg, id_rs) | reg_hit(idex_wreg, id_rt));
        req_cycles = 2'd1;
        fwd_a_raw  = 2'b00;
        fwd_b_raw  = 2'b00;
        if (exmem_regwrite && reg_hit(exmem_wreg, ex_rs)) begin
            fwd_a_raw = 2'b10;
        end else if (memwb_regwrite && reg_hit(memwb_wreg, ex_rs)) begin
            fwd_a_raw = 2'b01;
        end
        if (exmem_regwrite && reg_hit(exmem_wreg, ex_rt)) begin
            fwd_b_raw = 2'b10;
        end else if (memwb_regwrite && reg_hit(memwb_wreg, ex_rt)) begin
            fwd_b_raw = 2'b01;
        end
    end

    // The ID/EX write flag matters only to the non-forwarding detector.
    assign unused_inputs = idex_regwrite;
`else
    logic idex_hit, exmem_hit, memwb_hit;

    // Any live writer of an ID source stalls; the nearest writer decides how long.
    always_comb begin
        idex_hit   = idex_regwrite  & (reg_hit(idex_wreg, id_rs)  | reg_hit(idex_wreg, id_rt));
        exmem_hit  = exmem_regwrite & (reg_hit(exmem_wreg, id_rs) | reg_hit(exmem_wreg, id_rt));
        memwb_hit  = memwb_regwrite & (reg_hit(memwb_wreg, id_rs) | reg_hit(memwb_wreg, id_rt));
        hazard     = idex_hit | exmem_hit | memwb_hit;
        req_cycles = 2'd1;
        if (idex_hit) begin
            req_cycles = 2'd3;
        end else if (exmem_hit) begin
            req_cycles = 2'd2;
        end
        fwd_a_raw  = 2'b00;
        fwd_b_raw  = 2'b00;
    end

    // Load flag and EX-stage sources feed only the forwarding build.
    assign unused_inputs = ^{idex_memread, ex_rs, ex_rt};
`endif

    // Stall sequencer: the first stall cycle is issued from RUN, the rest are counted down in STALL.
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        stall_req = 1'b0;
        case (state_q)
            RUN: begin
                if (!br_taken && hazard) begin
                    stall_req = 1'b1;
                    if (req_cycles > 2'd1) begin
                        state_d = STALL;
                        scnt_d  = req_cycles - 2'd1;
                    end
                end
            end
            STALL: begin
                if (br_taken) begin
                    // The stalled instruction is being flushed anyway.
                    state_d = RUN;
                    scnt_d  = 2'd0;
                end else begin
                    stall_req = 1'b1;
                    if (scnt_q <= 2'd1) begin
                        state_d = RUN;
                        scnt_d  = 2'd0;
                    end else begin
                        scnt_d  = scnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                scnt_d  = 2'd0;
            end
        endcase
    end

    // Pipeline control outputs, forced quiet while reset is held.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rst) begin
            pc_hold     = stall_req;
            ifid_hold   = stall_req;
            idex_bubble = stall_req;
            ifid_flush  = br_taken;
            idex_flush  = br_taken;
            exmem_flush = br_taken;
            fwd_a       = fwd_a_raw;
            fwd_b       = fwd_b_raw;
        end
    end

    // Event counter next values, saturating at all-ones.
    always_comb begin
        stall_cnt_d = idex_bubble ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = br_taken    ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // FSM state and countdown registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            scnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    // Stall and flush event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_DIR_WIDTH, default 3: register-address width.
REQ-002 Parameter CNT_WIDTH, default 16: event-counter width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 id_rs, id_rt  input  REG_DIR_WIDTH each  source registers of the instruction in IF/ID.
REQ-006 idex_memread, idex_regwrite  input  1 each  control bits of the instruction in ID/EX.
REQ-007 idex_wreg  input  REG_DIR_WIDTH  destination of the ID/EX instruction, after the RegDst mux.
REQ-008 ex_rs, ex_rt  input  REG_DIR_WIDTH each  source registers of the ID/EX instruction.
REQ-009 exmem_regwrite, exmem_branch, exmem_zero  input  1 each  EX/MEM control and flag bits.
REQ-010 exmem_wreg  input  REG_DIR_WIDTH  destination of the EX/MEM instruction.
REQ-011 memwb_regwrite  input  1, memwb_wreg  input  REG_DIR_WIDTH  MEM/WB writer and its destination.
REQ-012 pc_hold, ifid_hold  output  1 each  freeze PC and IF/ID.
REQ-013 idex_bubble  output  1  load zero control into ID/EX.
REQ-014 ifid_flush, idex_flush, exmem_flush  output  1 each  clear those registers at the next edge.
REQ-015 fwd_a, fwd_b  output  2 each  ALU operand source: 00 = ID/EX, 10 = EX/MEM, 01 = MEM/WB.
REQ-016 stall_cnt, flush_cnt  output  CNT_WIDTH each  saturating event counters.

Function
REQ-017 Register 0 shall never be a hazard source; any comparison against address 0 shall be false.
REQ-018 br_taken = exmem_branch & exmem_zero.
REQ-019 While br_taken, ifid_flush, idex_flush and exmem_flush shall all be 1 combinationally in the same cycle.
REQ-020 While br_taken, hold and bubble outputs shall be 0, because the branch flush overrides every stall.
REQ-021 The FSM shall have two states: RUN and STALL, plus a 2-bit down-counter scnt.
REQ-022 In RUN with a hazard, pc_hold, ifid_hold and idex_bubble shall be 1 in that cycle.
REQ-023 In RUN with a hazard, the next state shall be STALL with scnt = required cycles - 1; if required = 1, the state shall stay RUN.
REQ-024 In STALL, pc_hold, ifid_hold and idex_bubble shall be 1, and scnt shall decrement each cycle.
REQ-025 In STALL, the FSM shall return to RUN when scnt = 0 at the edge.
REQ-026 br_taken in STALL shall force RUN and scnt = 0 at the next edge.
REQ-027 stall_cnt shall increment on every cycle with idex_bubble = 1 and saturate at all-ones.
REQ-028 flush_cnt shall increment on every cycle with br_taken = 1 and saturate at all-ones.
REQ-029 fwd_a shall select EX/MEM (10) when exmem_regwrite and exmem_wreg == ex_rs, otherwise MEM/WB (01) when memwb_regwrite and memwb_wreg == ex_rs, otherwise 00.
REQ-030 fwd_b shall follow the rule of REQ-029 using ex_rt.
REQ-031 Forwarding priority: EX/MEM shall win over MEM/WB.

Reset
REQ-032 rst low shall asynchronously set the state to RUN, scnt to 0, and both counters to 0.
REQ-033 While rst is low, every hold, bubble, flush and fwd output shall be 0.
REQ-034 Deassertion shall take effect at the first rising clk edge with rst high.
REQ-035 A stall in progress shall be abandoned on reset; no residual hold shall appear after reset.

Configuration
REQ-036 The macro HAZARD_FWD_EN shall select the forwarding behaviour.
REQ-037 With HAZARD_FWD_EN defined, forwarding per REQ-029..031 shall be active.
REQ-038 With HAZARD_FWD_EN defined, the only hazard shall be load-use: idex_memread & idex_wreg in {id_rs, id_rt}, requiring 1 cycle.
REQ-039 Without HAZARD_FWD_EN, fwd_a and fwd_b shall be tied to 00.
REQ-040 Without HAZARD_FWD_EN, any ID source matching a live writer shall be a hazard.
REQ-041 Without HAZARD_FWD_EN, required cycles shall be 3 for an ID/EX writer, 2 for EX/MEM and 1 for MEM/WB; the nearest matching writer shall set the count.

Verification
REQ-042 FWD_EN, lw $2 then add $3,$2,$1 -> one cycle with pc_hold = ifid_hold = idex_bubble = 1, stall_cnt = 1, then fwd_a = 01 on the add.
REQ-043 FWD_EN, add $2 then sub $4,$2,$2 -> no stall, fwd_a = fwd_b = 10.
REQ-044 No FWD_EN, add $2 immediately followed by a dependent add -> exactly 3 bubble cycles, stall_cnt = 3.
REQ-045 br_taken asserted while in STALL with scnt = 2 -> three flushes that cycle, RUN next cycle, flush_cnt = 1.
REQ-046 rst pulsed low mid-stall -> all outputs 0 immediately, state RUN after release, counters 0.
REQ-047 Force stall_cnt to all-ones via 2^CNT_WIDTH bubble cycles -> stall_cnt holds all-ones, no wrap.
